// File: rtl/program_memory_pkg.sv
// Shared sizing defaults, FSM state encoding and address helpers for the
// program memory and its CPU/loader interface.
package program_memory_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_MEM_ADDR_SIZE = 5;
  localparam int DEF_MEM_SIZE      = 32;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  // A CPU address is backed by storage only below the populated depth.
  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/program_memory_if.sv
// CPU access bus plus the streaming program-load port of the program memory.
// master = CPU core / boot source side, slave = the memory itself.
interface program_memory_if
  import program_memory_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE
);

  logic                     write_enable;
  logic [MEM_ADDR_SIZE-1:0] address;
  logic [WORD_SIZE-1:0]     data_in;
  logic [WORD_SIZE-1:0]     data_out;
  logic                     mem_ready;

  logic                     load_start;
  logic                     load_valid;
  logic [WORD_SIZE-1:0]     load_data;
  logic                     load_last;
  logic                     load_ready;
  logic                     load_done;
  logic                     load_error;

  modport master (
    output write_enable, address, data_in,
    output load_start, load_valid, load_data, load_last,
    input  data_out, mem_ready,
    input  load_ready, load_done, load_error
  );

  modport slave (
    input  write_enable, address, data_in,
    input  load_start, load_valid, load_data, load_last,
    output data_out, mem_ready,
    output load_ready, load_done, load_error
  );

endinterface

// File: rtl/program_memory_mem_array.sv
// Single write port storage with a registered read port; a same-cycle write to
// the read address is forwarded so the read returns the new word.
module mem_array #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 5,
  parameter int DEPTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WORD_SIZE-1:0] rd_data_p1
);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic                 fwd_p0;

  assign fwd_p0 = wr_en && (wr_addr == rd_addr);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // p0 -> p1: read register; holds its value whenever rd_en is low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data_p1 <= '0;
      end else if (fwd_p0) begin
        rd_data_p1 <= wr_data;
      end else begin
        rd_data_p1 <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/program_memory.sv
// CPU instruction/data memory with a post-reset clear sweep and a valid/ready
// program-load stream; the CPU owns the array only while mem_ready is high.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE  = DEF_MEM_ADDR_SIZE,
  parameter int MEM_SIZE       = DEF_MEM_SIZE,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  program_memory_if.slave   bus
);

  localparam logic [1:0]               RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR   = MEM_ADDR_SIZE'(MEM_SIZE - 1);

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [MEM_ADDR_SIZE-1:0] ptr;
  logic [MEM_ADDR_SIZE-1:0] ptr_nxt;

  logic                     cpu_en;
  logic                     cpu_in_range;
  logic                     load_accept;
  logic                     load_beat;
  logic                     load_end;
  logic                     overflow;

  logic                     wr_en;
  logic [MEM_ADDR_SIZE-1:0] wr_addr;
  logic [WORD_SIZE-1:0]     wr_data;

  // mem_ready is the registered image of "state is IDLE", so it also gates the
  // CPU side and stays low for the whole of reset.
  assign cpu_en       = bus.mem_ready;
  assign cpu_in_range = in_range(32'(bus.address), MEM_SIZE);
  assign load_accept  = cpu_en && bus.load_start;
  assign load_beat    = bus.load_ready && bus.load_valid;
  assign load_end     = load_beat && bus.load_last;
  assign overflow     = load_beat && !bus.load_last && (ptr == LAST_ADDR);

  // Write-port owner follows the state: CLEAR sweep, then loader, then CPU.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_en     = 1'b0;
    wr_addr   = bus.address;
    wr_data   = bus.data_in;
    case (state)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_data = '0;
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      ST_LOAD: begin
        wr_en   = load_beat;
        wr_addr = ptr;
        wr_data = bus.load_data;
        if (load_end || overflow) begin
          state_nxt = ST_IDLE;
        end else if (load_beat) begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: begin
        wr_en = cpu_en && bus.write_enable && cpu_in_range;
        if (load_accept) begin
          state_nxt = ST_LOAD;
          ptr_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RESET_STATE;
      ptr            <= '0;
      bus.mem_ready  <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      bus.mem_ready  <= (state_nxt == ST_IDLE);
      bus.load_ready <= (state_nxt == ST_LOAD);
      bus.load_done  <= load_end;
      if (load_accept) begin
        bus.load_error <= 1'b0;
      end else if (overflow) begin
        bus.load_error <= 1'b1;
      end
    end
  end

  mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_SIZE (MEM_ADDR_SIZE),
    .DEPTH     (MEM_SIZE)
  ) u_mem_array (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (cpu_en),
    .rd_zero    (!cpu_in_range),
    .rd_addr    (bus.address),
    .rd_data_p1 (bus.data_out)
  );

endmodule
